// File: rtl/alu_operand_stage_if.sv
// Signal bundle between the decode/forwarding side and the ID/EX operand stage.
// Valid/hold semantics: a decode slot is consumed on a rising edge only when d_valid=1 and neither stall nor stall_req is high.
interface alu_operand_stage_if;
    logic        d_valid;
    logic [31:0] d_rs_val;
    logic [31:0] d_rt_val;
    logic [31:0] d_imm;
    logic [4:0]  d_rs_addr;
    logic [4:0]  d_rt_addr;
    logic [4:0]  d_rd_addr;
    logic [3:0]  d_ex_cmd;
    logic [1:0]  d_ALUOp;
    logic        d_branch;
    logic        d_alusrc;
    logic        d_regwrite;
    logic        d_memread;
    logic        stall;
    logic        flush;
    logic        exm_regwrite;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        mwb_regwrite;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_result;
    logic        flag;
    logic [31:0] input1;
    logic [31:0] input2;
    logic [3:0]  ex_cmd;
    logic [1:0]  ALUOp;
    logic        branchD;
    logic        e_valid;
    logic        e_regwrite;
    logic        e_memread;
    logic [4:0]  e_rd_addr;
    logic [31:0] e_store_data;
    logic        stall_req;
    logic        branch_taken;

    modport master (
        output d_valid, d_rs_val, d_rt_val, d_imm, d_rs_addr, d_rt_addr, d_rd_addr,
               d_ex_cmd, d_ALUOp, d_branch, d_alusrc, d_regwrite, d_memread,
               stall, flush, exm_regwrite, exm_rd, exm_result,
               mwb_regwrite, mwb_rd, mwb_result, flag,
        input  input1, input2, ex_cmd, ALUOp, branchD, e_valid, e_regwrite,
               e_memread, e_rd_addr, e_store_data, stall_req, branch_taken
    );

    modport slave (
        input  d_valid, d_rs_val, d_rt_val, d_imm, d_rs_addr, d_rt_addr, d_rd_addr,
               d_ex_cmd, d_ALUOp, d_branch, d_alusrc, d_regwrite, d_memread,
               stall, flush, exm_regwrite, exm_rd, exm_result,
               mwb_regwrite, mwb_rd, mwb_result, flag,
        output input1, input2, ex_cmd, ALUOp, branchD, e_valid, e_regwrite,
               e_memread, e_rd_addr, e_store_data, stall_req, branch_taken
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX register stage feeding the ALU: operand forwarding, load-use stall
// detection and branch qualification.
module alu_operand_stage (
    input  logic                  clk,
    input  logic                  reset_n,
    alu_operand_stage_if.slave    bus
);

    logic        r_valid;
    logic [31:0] r_rs_val;
    logic [31:0] r_rt_val;
    logic [31:0] r_imm;
    logic [4:0]  r_rs_addr;
    logic [4:0]  r_rt_addr;
    logic [4:0]  r_rd_addr;
    logic [3:0]  r_ex_cmd;
    logic [1:0]  r_aluop;
    logic        r_branch;
    logic        r_alusrc;
    logic        r_regwrite;
    logic        r_memread;

    logic        hazard;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    // Register 0 is hard-wired, so it is never a forwarding target.
    function automatic logic [31:0] fwd(
        input logic [4:0]  addr,
        input logic [31:0] stored,
        input logic        exm_we,
        input logic [4:0]  exm_rd,
        input logic [31:0] exm_val,
        input logic        mwb_we,
        input logic [4:0]  mwb_rd,
        input logic [31:0] mwb_val
    );
        logic [31:0] res;
        res = stored;
        if (addr != 5'd0) begin
            if (exm_we && exm_rd == addr)
                res = exm_val;
            else if (mwb_we && mwb_rd == addr)
                res = mwb_val;
        end
        return res;
    endfunction

    // A load still in this stage cannot feed its dependent through EX/MEM.
    assign hazard = bus.d_valid && r_valid && r_memread && (r_rd_addr != 5'd0) &&
                    ((r_rd_addr == bus.d_rs_addr) ||
                     ((r_rd_addr == bus.d_rt_addr) && !bus.d_alusrc));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid    <= 1'b0;
            r_rs_val   <= '0;
            r_rt_val   <= '0;
            r_imm      <= '0;
            r_rs_addr  <= '0;
            r_rt_addr  <= '0;
            r_rd_addr  <= '0;
            r_ex_cmd   <= '0;
            r_aluop    <= '0;
            r_branch   <= 1'b0;
            r_alusrc   <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
        end else if (bus.flush || (!bus.stall && (hazard || !bus.d_valid))) begin
            r_valid    <= 1'b0;
            r_ex_cmd   <= '0;
            r_aluop    <= '0;
            r_branch   <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
        end else if (!bus.stall) begin
            r_valid    <= 1'b1;
            r_rs_val   <= bus.d_rs_val;
            r_rt_val   <= bus.d_rt_val;
            r_imm      <= bus.d_imm;
            r_rs_addr  <= bus.d_rs_addr;
            r_rt_addr  <= bus.d_rt_addr;
            r_rd_addr  <= bus.d_rd_addr;
            r_ex_cmd   <= bus.d_ex_cmd;
            r_aluop    <= bus.d_ALUOp;
            r_branch   <= bus.d_branch;
            r_alusrc   <= bus.d_alusrc;
            r_regwrite <= bus.d_regwrite;
            r_memread  <= bus.d_memread;
        end
    end

    always_comb begin
        fwd_rs = fwd(r_rs_addr, r_rs_val, bus.exm_regwrite, bus.exm_rd, bus.exm_result,
                     bus.mwb_regwrite, bus.mwb_rd, bus.mwb_result);
        fwd_rt = fwd(r_rt_addr, r_rt_val, bus.exm_regwrite, bus.exm_rd, bus.exm_result,
                     bus.mwb_regwrite, bus.mwb_rd, bus.mwb_result);
    end

    assign bus.input1       = fwd_rs;
    assign bus.input2       = r_alusrc ? r_imm : fwd_rt;
    assign bus.e_store_data = fwd_rt;
    assign bus.ex_cmd       = r_ex_cmd;
    assign bus.ALUOp        = r_aluop;
    assign bus.branchD      = r_branch & r_valid;
    assign bus.e_valid      = r_valid;
    assign bus.e_regwrite   = r_regwrite;
    assign bus.e_memread    = r_memread;
    assign bus.e_rd_addr    = r_rd_addr;
    assign bus.stall_req    = hazard;
    assign bus.branch_taken = r_valid & r_branch & bus.flag;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: literal checks plus a per-cycle
// comparison against an instruction-level model of the stage.
module tb_alu_operand_stage;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  alu_operand_stage_if bus ();

  alu_operand_stage dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [3:0]  cmd;
    logic [1:0]  aluop;
    logic        branch;
    logic        alusrc;
    logic        regwrite;
    logic        memread;
  } inst_t;

  inst_t m;

  function automatic logic [31:0] model_operand(input logic [4:0] a, input logic [31:0] stored);
    if (a == 0) return stored;
    if (bus.exm_regwrite && bus.exm_rd == a) return bus.exm_result;
    if (bus.mwb_regwrite && bus.mwb_rd == a) return bus.mwb_result;
    return stored;
  endfunction

  function automatic logic model_hazard();
    return bus.d_valid && m.valid && m.memread && m.rd != 0 &&
           (m.rd == bus.d_rs_addr || (m.rd == bus.d_rt_addr && !bus.d_alusrc));
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m <= '0;
    end else if (bus.flush) begin
      m <= '0;
    end else if (bus.stall) begin
      m <= m;
    end else if (model_hazard() || !bus.d_valid) begin
      m <= '0;
    end else begin
      m <= '{valid: 1'b1, rs_val: bus.d_rs_val, rt_val: bus.d_rt_val, imm: bus.d_imm,
             rs: bus.d_rs_addr, rt: bus.d_rt_addr, rd: bus.d_rd_addr,
             cmd: bus.d_ex_cmd, aluop: bus.d_ALUOp, branch: bus.d_branch,
             alusrc: bus.d_alusrc, regwrite: bus.d_regwrite, memread: bus.d_memread};
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_e_valid", 32'(bus.e_valid), 32'(m.valid));
    chk("cmp_ex_cmd", 32'(bus.ex_cmd), 32'(m.cmd));
    chk("cmp_aluop", 32'(bus.ALUOp), 32'(m.aluop));
    chk("cmp_branchD", 32'(bus.branchD), 32'(m.branch && m.valid));
    chk("cmp_regwrite", 32'(bus.e_regwrite), 32'(m.regwrite));
    chk("cmp_memread", 32'(bus.e_memread), 32'(m.memread));
    chk("cmp_taken", 32'(bus.branch_taken), 32'(m.valid && m.branch && bus.flag));
    chk("cmp_stall_req", 32'(bus.stall_req), 32'(model_hazard()));
    if (m.valid) begin
      chk("cmp_input1", bus.input1, model_operand(m.rs, m.rs_val));
      chk("cmp_input2", bus.input2, m.alusrc ? m.imm : model_operand(m.rt, m.rt_val));
      chk("cmp_store", bus.e_store_data, model_operand(m.rt, m.rt_val));
      chk("cmp_rd", 32'(bus.e_rd_addr), 32'(m.rd));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.d_valid = 0; bus.d_rs_val = 0; bus.d_rt_val = 0; bus.d_imm = 0;
    bus.d_rs_addr = 0; bus.d_rt_addr = 0; bus.d_rd_addr = 0;
    bus.d_ex_cmd = 0; bus.d_ALUOp = 0; bus.d_branch = 0; bus.d_alusrc = 0;
    bus.d_regwrite = 0; bus.d_memread = 0; bus.stall = 0; bus.flush = 0;
    bus.exm_regwrite = 0; bus.exm_rd = 0; bus.exm_result = 0;
    bus.mwb_regwrite = 0; bus.mwb_rd = 0; bus.mwb_result = 0; bus.flag = 0;
  endtask

  task automatic drive_inst(input logic [4:0] rs, input logic [31:0] rs_val,
                            input logic [4:0] rt, input logic [31:0] rt_val,
                            input logic [4:0] rd, input logic [3:0] cmd, input logic [1:0] aluop);
    bus.d_valid = 1; bus.d_rs_addr = rs; bus.d_rs_val = rs_val;
    bus.d_rt_addr = rt; bus.d_rt_val = rt_val; bus.d_rd_addr = rd;
    bus.d_ex_cmd = cmd; bus.d_ALUOp = aluop; bus.d_regwrite = 1;
    bus.d_memread = 0; bus.d_alusrc = 0; bus.d_branch = 0; bus.d_imm = 0;
  endtask

  task automatic randomize_inputs();
    bus.d_valid = ($urandom_range(0, 3) != 0);
    bus.d_rs_val = $urandom(); bus.d_rt_val = $urandom(); bus.d_imm = $urandom();
    bus.d_rs_addr = 5'($urandom_range(0, 3)); bus.d_rt_addr = 5'($urandom_range(0, 3));
    bus.d_rd_addr = 5'($urandom_range(0, 3));
    bus.d_ex_cmd = 4'($urandom_range(0, 15)); bus.d_ALUOp = 2'($urandom_range(0, 3));
    bus.d_branch = 1'($urandom_range(0, 1)); bus.d_alusrc = 1'($urandom_range(0, 1));
    bus.d_regwrite = 1'($urandom_range(0, 1)); bus.d_memread = 1'($urandom_range(0, 1));
    bus.stall = ($urandom_range(0, 7) == 0); bus.flush = ($urandom_range(0, 9) == 0);
    bus.exm_regwrite = 1'($urandom_range(0, 1)); bus.exm_rd = 5'($urandom_range(0, 3));
    bus.exm_result = $urandom();
    bus.mwb_regwrite = 1'($urandom_range(0, 1)); bus.mwb_rd = 5'($urandom_range(0, 3));
    bus.mwb_result = $urandom();
    bus.flag = 1'($urandom_range(0, 1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    total = 0;
    bad = 0;
    clear_inputs();
    reset_n = 0;

    // Reset with a live-looking decode slot
    randomize_inputs();
    bus.d_valid = 1; bus.stall = 0; bus.flush = 0;
    repeat (3) tick();
    chk("rst_input1", bus.input1, 32'd0);
    chk("rst_input2", bus.input2, 32'd0);
    chk("rst_ex_cmd", 32'(bus.ex_cmd), 32'd0);
    chk("rst_e_valid", 32'(bus.e_valid), 32'd0);
    chk("rst_regwrite", 32'(bus.e_regwrite), 32'd0);
    chk("rst_store", bus.e_store_data, 32'd0);
    chk("rst_stall_req", 32'(bus.stall_req), 32'd0);
    chk("rst_taken", 32'(bus.branch_taken), 32'd0);

    // First instruction after reset
    clear_inputs();
    reset_n = 1;
    drive_inst(5'd1, 32'd88, 5'd2, 32'd88, 5'd4, 4'b1111, 2'd2);
    tick();
    chk("first_input1", bus.input1, 32'd88);
    chk("first_input2", bus.input2, 32'd88);
    chk("first_ex_cmd", 32'(bus.ex_cmd), 32'd15);
    chk("first_aluop", 32'(bus.ALUOp), 32'd2);

    // Forward priority: EX/MEM beats MEM/WB; r0 never forwarded
    drive_inst(5'd5, 32'd100, 5'd6, 32'd200, 5'd10, 4'd1, 2'd0);
    tick();
    bus.d_valid = 0;
    bus.exm_regwrite = 1; bus.exm_rd = 5; bus.exm_result = 7;
    bus.mwb_regwrite = 1; bus.mwb_rd = 5; bus.mwb_result = 9;
    #1 chk("fwd_exm_wins", bus.input1, 32'd7);
    bus.exm_regwrite = 0;
    #1 chk("fwd_mwb", bus.input1, 32'd9);
    drive_inst(5'd0, 32'd55, 5'd6, 32'd200, 5'd10, 4'd1, 2'd0);
    tick();
    bus.d_valid = 0;
    bus.exm_regwrite = 1; bus.exm_rd = 0; bus.exm_result = 7;
    bus.mwb_regwrite = 1; bus.mwb_rd = 0; bus.mwb_result = 9;
    #1 chk("fwd_r0_stored", bus.input1, 32'd55);

    // Load-use: one bubble, then MEM/WB supplies the load result
    clear_inputs();
    drive_inst(5'd1, 32'd0, 5'd2, 32'd0, 5'd3, 4'd0, 2'd0);
    bus.d_memread = 1;
    tick();
    drive_inst(5'd3, 32'd0, 5'd4, 32'd0, 5'd6, 4'd2, 2'd1);
    #1 chk("lu_stall_req", 32'(bus.stall_req), 32'd1);
    tick();
    chk("lu_bubble_valid", 32'(bus.e_valid), 32'd0);
    chk("lu_bubble_cmd", 32'(bus.ex_cmd), 32'd0);
    chk("lu_bubble_release", 32'(bus.stall_req), 32'd0);
    tick();
    bus.d_valid = 0;
    bus.mwb_regwrite = 1; bus.mwb_rd = 3; bus.mwb_result = 42;
    #1 chk("lu_fwd_input1", bus.input1, 32'd42);
    chk("lu_dep_valid", 32'(bus.e_valid), 32'd1);
    chk("lu_dep_cmd", 32'(bus.ex_cmd), 32'd2);

    // Immediate operand with forwarded store data
    clear_inputs();
    drive_inst(5'd0, 32'd0, 5'd7, 32'd0, 5'd9, 4'd3, 2'd0);
    bus.d_alusrc = 1; bus.d_imm = 32'hFFFF_FFFC;
    tick();
    bus.d_valid = 0;
    bus.exm_regwrite = 1; bus.exm_rd = 7; bus.exm_result = 11;
    #1 chk("imm_input2", bus.input2, 32'hFFFF_FFFC);
    chk("imm_store", bus.e_store_data, 32'd11);
    clear_inputs();
    drive_inst(5'd1, 32'd0, 5'd2, 32'd0, 5'd8, 4'd0, 2'd0);
    bus.d_memread = 1;
    tick();
    drive_inst(5'd9, 32'd0, 5'd8, 32'd0, 5'd12, 4'd0, 2'd0);
    bus.d_alusrc = 1;
    #1 chk("imm_no_hazard", 32'(bus.stall_req), 32'd0);
    bus.d_alusrc = 0;
    #1 chk("rt_hazard", 32'(bus.stall_req), 32'd1);
    bus.d_valid = 0;

    // Stall holds, flush beats stall
    tick();
    drive_inst(5'd1, 32'd123, 5'd2, 32'd77, 5'd5, 4'd5, 2'd1);
    bus.d_branch = 1;
    tick();
    bus.stall = 1;
    drive_inst(5'd2, 32'd999, 5'd3, 32'd888, 5'd6, 4'd9, 2'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_input1", bus.input1, 32'd123);
      chk("stall_ex_cmd", 32'(bus.ex_cmd), 32'd5);
    end
    bus.flush = 1;
    tick();
    chk("flush_valid", 32'(bus.e_valid), 32'd0);
    chk("flush_branchD", 32'(bus.branchD), 32'd0);

    // Branch qualification
    clear_inputs();
    drive_inst(5'd1, 32'd1, 5'd2, 32'd1, 5'd0, 4'd6, 2'd1);
    bus.d_branch = 1; bus.d_regwrite = 0;
    tick();
    bus.d_valid = 0;
    bus.flag = 1;
    #1 chk("br_taken", 32'(bus.branch_taken), 32'd1);
    bus.flush = 1;
    tick();
    chk("br_flushed", 32'(bus.branch_taken), 32'd0);

    // Mixed vectors checked cycle by cycle against the model
    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      tick();
    end

    // Asynchronous reset mid-operation discards the instruction at once
    clear_inputs();
    drive_inst(5'd1, 32'd5, 5'd2, 32'd6, 5'd7, 4'd4, 2'd2);
    bus.d_memread = 1;
    tick();
    bus.d_valid = 0;
    #1 reset_n = 0;
    #1 chk("midrst_regwrite", 32'(bus.e_regwrite), 32'd0);
    chk("midrst_valid", 32'(bus.e_valid), 32'd0);
    chk("midrst_memread", 32'(bus.e_memread), 32'd0);
    tick();
    reset_n = 1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
